uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_if.sv | 25 ++
 rtl/uart_tx_bit_timer.sv | 36 +++
 rtl/uart_tx.sv | 122 ++++++++++++
 tb/tb_uart_tx.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-type constants and frame sizing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  // Start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_width, input logic par_en);
    return data_width + 2 + int'(par_en);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side request bus and serial line of the UART transmitter.
interface uart_tx_if #(
  parameter int unsigned Data_Width     = 8,
  parameter int unsigned Prescale_Width = 6
);

  logic [Data_Width-1:0]     P_DATA;
  logic                      Data_Valid;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [Prescale_Width-1:0] Prescale;
  logic                      TX_OUT;
  logic                      Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    output TX_OUT, Busy
  );

endinterface

// File: rtl/uart_tx_bit_timer.sv
// Per-bit cycle counter; bit_done marks the last cycle of each bit period.
module uart_tx_bit_timer #(
  parameter int unsigned Prescale_Width = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [Prescale_Width-1:0] prescale,
  input  logic                      en,
  input  logic                      clr,
  output logic                      bit_done
);

  logic [Prescale_Width-1:0] cnt_q, cnt_d;
  logic [Prescale_Width-1:0] last;

  always_comb begin
    // A prescale of zero behaves as one cycle per bit.
    last     = (prescale == '0) ? '0 : prescale - 1'b1;
    bit_done = en && (cnt_q == last);
    cnt_d    = cnt_q;
    if (clr || !en || bit_done) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises one latched word per accepted Data_Valid onto TX_OUT.
module uart_tx #(
  parameter int unsigned Data_Width     = 8,
  parameter int unsigned Prescale_Width = 6
) (
  input logic      CLK,
  input logic      RST,
  uart_tx_if.slave bus
);
  import uart_pkg::*;

  localparam int unsigned IW = (Data_Width > 1) ? $clog2(Data_Width) : 1;

  uart_state_e               state_q, state_d;
  logic [Data_Width-1:0]     data_q, data_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic [Prescale_Width-1:0] pl_q, pl_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      bit_done;
  logic                      parity;

  uart_tx_bit_timer #(
    .Prescale_Width(Prescale_Width)
  ) u_bit_timer (
    .clk      (CLK),
    .rst      (RST),
    .prescale (pl_q),
    .en       (busy_q),
    .clr      (!busy_q),
    .bit_done (bit_done)
  );

  assign parity = (^data_q) ^ (par_typ_q == ODD);

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    pl_d      = pl_q;
    idx_d     = idx_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.Data_Valid) begin
          state_d   = START;
          data_d    = bus.P_DATA;
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
          pl_d      = bus.Prescale;
          idx_d     = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == IW'(Data_Width - 1)) begin
            state_d = par_en_q ? PARITY : STOP;
            tx_d    = par_en_q ? parity : 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = data_q[idx_d];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      pl_q      <= '0;
      idx_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      pl_q      <= pl_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle line/Busy comparison against a frame model,
// plus a behavioural receiver for loopback.
module tb_uart_tx;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  uart_tx_if #(.Data_Width(8), .Prescale_Width(6)) bus ();

  uart_tx #(.Data_Width(8), .Prescale_Width(6)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural receiver: samples mid-bit from the first low cycle of the start bit.
  bit             rx_en = 1'b0;
  int unsigned    rx_pl = 8;
  bit             rx_pe = 1'b0;
  bit             rx_pt = 1'b0;
  logic [7:0]     rx_words[$];
  bit             rx_perr[$];
  bit             rx_serr[$];

  initial begin
    logic [7:0] w;
    logic       p;
    logic       s;
    forever begin
      @(negedge clk);
      if (rx_en && bus.TX_OUT === 1'b0) begin
        w = '0;
        p = 1'b0;
        repeat (rx_pl / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (rx_pl) @(negedge clk);
          w[i] = bus.TX_OUT;
        end
        if (rx_pe) begin
          repeat (rx_pl) @(negedge clk);
          p = bus.TX_OUT;
        end
        repeat (rx_pl) @(negedge clk);
        s = bus.TX_OUT;
        rx_words.push_back(w);
        rx_perr.push_back(rx_pe && (p !== ((^w) ^ rx_pt)));
        rx_serr.push_back(s !== 1'b1);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level for frame bit k: start, data LSB first, optional parity, stop/idle.
  function automatic logic exp_bit(input logic [7:0] d, input logic pe, input logic pt,
                                   input int unsigned k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && pe) return (^d) ^ pt;
    return 1'b1;
  endfunction

  task automatic drive(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Prescale   = ps;
    bus.Data_Valid = 1'b1;
  endtask

  // Expects the accept on the next rising edge, checks every cycle of the frame, then
  // checks the first idle cycle. Returns at that idle cycle's falling edge.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                           input logic pt, input logic [5:0] ps, input bit keep_dv,
                           input bit scramble);
    int unsigned pl;
    int unsigned len;
    pl  = (ps == 0) ? 1 : ps;
    len = (10 + pe) * pl;
    @(posedge clk);
    #1;
    if (!keep_dv) bus.Data_Valid = 1'b0;
    for (int unsigned c = 0; c < len; c++) begin
      @(negedge clk);
      check({tag, "_tx"}, bus.TX_OUT, exp_bit(d, pe, pt, c / pl));
      check({tag, "_busy"}, bus.Busy, 1'b1);
      if (scramble && c == len / 2) begin
        bus.P_DATA   = ~d;
        bus.PAR_EN   = ~pe;
        bus.PAR_TYP  = ~pt;
        bus.Prescale = 6'd16;
      end
    end
    @(negedge clk);
    check({tag, "_idle_tx"}, bus.TX_OUT, 1'b1);
    check({tag, "_idle_busy"}, bus.Busy, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic [5:0] ps;

    rst            = 1'b1;
    bus.P_DATA     = '0;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Prescale   = 6'd8;
    #1;
    check("reset_tx", bus.TX_OUT, 1'b1);
    check("reset_busy", bus.Busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_tx", bus.TX_OUT, 1'b1);
    check("post_reset_busy", bus.Busy, 1'b0);

    // Plain 8N1 frame.
    drive(8'h99, 1'b0, 1'b0, 6'd8);
    run_frame("t1", 8'h99, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0);

    // Even then odd parity.
    drive(8'hA7, 1'b1, 1'b0, 6'd8);
    run_frame("t2e", 8'hA7, 1'b1, 1'b0, 6'd8, 1'b0, 1'b0);
    drive(8'hA7, 1'b1, 1'b1, 6'd8);
    run_frame("t2o", 8'hA7, 1'b1, 1'b1, 6'd8, 1'b0, 1'b0);

    // Loopback, back-to-back frames.
    rx_pl = 8;
    rx_pe = 1'b1;
    rx_pt = 1'b0;
    rx_en = 1'b1;
    drive(8'h99, 1'b1, 1'b0, 6'd8);
    run_frame("t3a", 8'h99, 1'b1, 1'b0, 6'd8, 1'b1, 1'b0);
    drive(8'h55, 1'b1, 1'b0, 6'd8);
    run_frame("t3b", 8'h55, 1'b1, 1'b0, 6'd8, 1'b0, 1'b0);
    rx_en = 1'b0;
    check("t3_rx_count", rx_words.size(), 2);
    if (rx_words.size() == 2) begin
      check("t3_rx_word0", rx_words[0], 8'h99);
      check("t3_rx_word1", rx_words[1], 8'h55);
      check("t3_par_err", {rx_perr[0], rx_perr[1]}, 2'b00);
      check("t3_stp_err", {rx_serr[0], rx_serr[1]}, 2'b00);
    end

    // Data_Valid held through the frame with inputs changing mid-frame.
    d = 8'($urandom);
    drive(d, 1'b0, 1'b1, 6'd3);
    run_frame("t4a", d, 1'b0, 1'b1, 6'd3, 1'b1, 1'b1);
    d = 8'($urandom);
    drive(d, 1'b1, 1'b1, 6'd2);
    run_frame("t4b", d, 1'b1, 1'b1, 6'd2, 1'b0, 1'b0);

    // Asynchronous reset during the 4th data bit, then a clean frame.
    d = 8'($urandom);
    drive(d, 1'b1, 1'b0, 6'd4);
    @(posedge clk);
    #1;
    bus.Data_Valid = 1'b0;
    repeat (4 * 4 + 2) @(negedge clk);
    check("t5_pre_busy", bus.Busy, 1'b1);
    check("t5_pre_tx", bus.TX_OUT, d[3]);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_tx", bus.TX_OUT, 1'b1);
    check("t5_async_busy", bus.Busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_after_tx", bus.TX_OUT, 1'b1);
    check("t5_after_busy", bus.Busy, 1'b0);
    d = 8'($urandom);
    drive(d, 1'b0, 1'b0, 6'd4);
    run_frame("t5", d, 1'b0, 1'b0, 6'd4, 1'b0, 1'b0);

    // One-cycle bits, with Prescale moved to 16 mid-frame.
    drive(8'h01, 1'b0, 1'b0, 6'd0);
    run_frame("t6p0", 8'h01, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    drive(8'h01, 1'b0, 1'b0, 6'd1);
    run_frame("t6p1", 8'h01, 1'b0, 1'b0, 6'd1, 1'b0, 1'b1);

    // Randomized frames.
    for (int i = 0; i < 8; i++) begin
      d  = 8'($urandom);
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      ps = 6'($urandom_range(0, 5));
      drive(d, pe, pt, ps);
      run_frame("rnd", d, pe, pt, ps, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
